// File: rtl/little_cpu_pkg.sv
// Shared definitions for the little CPU memory subsystem: default geometry
// and the responder state encoding.
package little_cpu_pkg;

    localparam int BITS_DEF      = 16;
    localparam int ADDR_BITS_DEF = 8;
    localparam int CNT_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Word-organised storage with one synchronous write port (low byte or full
// word) and a registered synchronous read port.
module mem_array
    import little_cpu_pkg::*;
#(
    parameter int BITS      = BITS_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_we,
    input  logic                 i_full,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [BITS-1:0]      i_wdata,
    input  logic                 i_re,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [BITS-1:0]      o_rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [BITS-1:0] mem_q [0:DEPTH-1];
    logic [BITS-1:0] rdata_q;

    // Contents are deliberately not reset; only the read register is.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            if (i_full) mem_q[i_waddr]      <= i_wdata;
            else        mem_q[i_waddr][7:0] <= i_wdata[7:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  rdata_q <= '0;
        else if (i_re) rdata_q <= mem_q[i_raddr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// CPU-facing memory responder: latches one access, inserts WAIT_STATES wait
// cycles, acks for one cycle, and lets a loader write whole words when idle.
module mem_responder
    import little_cpu_pkg::*;
#(
    parameter int BITS        = BITS_DEF,
    parameter int ADDR_BITS   = ADDR_BITS_DEF,
    parameter int WAIT_STATES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [7:0]           i_wdata,
    input  logic                 i_ld_we,
    input  logic [ADDR_BITS-1:0] i_ld_addr,
    input  logic [BITS-1:0]      i_ld_data,
    output logic [BITS-1:0]      o_rdata,
    output logic                 o_ack,
    output logic                 o_busy,
    output logic                 o_ld_rdy
);

    localparam logic [CNT_W-1:0] WS_CNT = CNT_W'(WAIT_STATES);

    mem_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [7:0]             wdata_q, wdata_d;

    logic                   start_resp, cpu_wr, cpu_rd, ld_wr;
    logic [BITS-1:0]        cpu_word;
    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_waddr;
    logic [BITS-1:0]        mem_wdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    we_d    = i_we;
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                    cnt_d   = WS_CNT;
                    state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // The memory access happens on the edge that enters RESP, so the _d
    // request fields (fresh inputs when coming straight from IDLE) drive it.
    assign start_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign cpu_wr     = start_resp && we_d;
    assign cpu_rd     = start_resp && !we_d;

    assign o_ld_rdy   = (state_q == ST_IDLE) && !i_req;
    assign ld_wr      = i_ld_we && o_ld_rdy;

    always_comb begin
        cpu_word      = '0;
        cpu_word[7:0] = wdata_d;
    end

    // cpu_wr and ld_wr are mutually exclusive: ld_rdy is low whenever a CPU
    // access can be entering RESP.
    assign mem_we    = cpu_wr || ld_wr;
    assign mem_waddr = ld_wr ? i_ld_addr : addr_d;
    assign mem_wdata = ld_wr ? i_ld_data : cpu_word;

    mem_array #(
        .BITS      (BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (mem_we),
        .i_full  (ld_wr),
        .i_waddr (mem_waddr),
        .i_wdata (mem_wdata),
        .i_re    (cpu_rd),
        .i_raddr (addr_d),
        .o_rdata (o_rdata)
    );

    assign o_ack  = (state_q == ST_RESP);
    assign o_busy = (state_q == ST_WAIT) || (state_q == ST_RESP);

endmodule
